uart_tx_cfg: RTL

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parameterised UART transmitter (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits). Every bit lasts DIV = CLK_HZ/BAUD cycles.
// Optional feature macro: UART_TX_PARITY_EN adds one parity bit after the data bits
// (even parity when PARITY_ODD=0, odd when PARITY_ODD=1). Without the macro the
// PARITY state and all parity logic are absent.
module uart_tx_cfg #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 txd
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    // Bit counter is shared by the data bits (0..DATA_BITS-1) and stop bits (0..STOP_BITS-1).
    localparam int BIT_W = 3;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration time.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_cfg: CLK_HZ/BAUD must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
            $error("uart_tx_cfg: DATA_BITS must be 5..8");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
            $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic [CNT_W-1:0]     baud_cnt, baud_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic                 txd_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 baud_done;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit, par_n;
`endif

    assign baud_done = (baud_cnt == CNT_LAST);
    assign tx_ready  = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    // Next-state, counter, shift-register and line-level decode; txd is computed one
    // cycle ahead so the registered line changes exactly on bit boundaries.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        txd_n   = txd;
        shreg_n = shreg;
`ifdef UART_TX_PARITY_EN
        par_n   = par_bit;
`endif
        case (state)
            IDLE: begin
                txd_n  = 1'b1;
                baud_n = '0;
                bit_n  = '0;
                if (tx_valid && tx_ready) begin
                    state_n = START;
                    txd_n   = 1'b0;
                    shreg_n = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_n   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = DATA;
                    txd_n   = shreg[0];
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_cnt == DATA_LAST) begin
                        bit_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = par_bit;
`else
                        state_n = STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        shreg_n = shreg >> 1;
                        txd_n   = shreg[1];
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = STOP;
                    txd_n   = 1'b1;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                txd_n = 1'b1;
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_n   = '0;
                        state_n = IDLE;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
                bit_n   = '0;
                txd_n   = 1'b1;
            end
        endcase
    end

    // Control state: reset aborts any frame on the same edge and forces the line idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            txd      <= txd_n;
        end
    end

    // Payload holding registers; only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        shreg   <= shreg_n;
`ifdef UART_TX_PARITY_EN
        par_bit <= par_n;
`endif
    end

endmodule
